inc_dec_arbiter: RTL and testbench

INC_DEC_ARBITER -- requirements
Module: inc_dec_arbiter

---
 rtl/pb_ctrl_pkg.sv | 20 ++
 rtl/req_pending_latch.sv | 29 ++
 rtl/inc_dec_arbiter.sv | 176 +++++++++++++++++
 tb/tb_inc_dec_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_ctrl_pkg.sv
// Shared types for the push-button control slice: arbiter FSM states and
// the grant encoding used between the arbiter and its pending latches.
package pb_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HOLDOFF = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INC  = 2'd1,
    GNT_DEC  = 2'd2,
    GNT_CLR  = 2'd3
  } grant_e;

  // Holdoff down-counter width; holds holdoff lengths up to 255 cycles.
  localparam int HOLD_W = 8;

endpackage

// File: rtl/req_pending_latch.sv
// One pending bit for a single request type. Repeated requests merge into
// the one bit; a request that lands on an already-pending bit is reported
// as lost, except on the edge that grants (or flushes) that bit.
module req_pending_latch (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic grant,
  input  logic flush,
  output logic pending,
  output logic lost_hit
);

  // Pending bit: flush wins, a grant re-arms only from a same-edge request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (flush) begin
      pending <= 1'b0;
    end else if (grant) begin
      pending <= req;
    end else if (req) begin
      pending <= 1'b1;
    end
  end

  assign lost_hit = req & pending & ~grant & ~flush;

endmodule

// File: rtl/inc_dec_arbiter.sv
// Arbitrates increment / decrement / clear pulses onto one counter, with a
// fixed holdoff after every accepted update. All outputs are registered or
// derived from registered state only.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | may grant one pending request this edge
//   HOLDOFF | counting down N_HOLDOFF cycles; requests latch but wait
module inc_dec_arbiter
  import pb_ctrl_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int N_HOLDOFF = 4,
  parameter int WRAP      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_req,
  input  logic             dec_req,
  input  logic             clr_req,
  output logic [WIDTH-1:0] count,
  output logic             ack_inc,
  output logic             ack_dec,
  output logic             ack_clr,
  output logic             busy,
  output logic             ovf,
  output logic             unf,
  output logic             lost
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_e            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  grant_e            gnt, last_grant;
  logic [WIDTH-1:0]  count_nxt;
  logic              ovf_nxt, unf_nxt;
  logic              pend_inc, pend_dec, pend_clr;
  logic              hit_inc, hit_dec, hit_clr;
  logic              gnt_clr;

  assign gnt_clr = (gnt == GNT_CLR);

  req_pending_latch u_pend_inc (
    .clk      (clk),
    .rst      (rst),
    .req      (inc_req),
    .grant    (gnt == GNT_INC),
    .flush    (gnt_clr),
    .pending  (pend_inc),
    .lost_hit (hit_inc)
  );

  req_pending_latch u_pend_dec (
    .clk      (clk),
    .rst      (rst),
    .req      (dec_req),
    .grant    (gnt == GNT_DEC),
    .flush    (gnt_clr),
    .pending  (pend_dec),
    .lost_hit (hit_dec)
  );

  req_pending_latch u_pend_clr (
    .clk      (clk),
    .rst      (rst),
    .req      (clr_req),
    .grant    (gnt_clr),
    .flush    (1'b0),
    .pending  (pend_clr),
    .lost_hit (hit_clr)
  );

  // FSM state and holdoff down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Grant selection, next state and next counter value.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    gnt          = GNT_NONE;
    count_nxt    = count;
    ovf_nxt      = 1'b0;
    unf_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (pend_clr) begin
          gnt = GNT_CLR;
        end else if (pend_inc && pend_dec) begin
          // whichever of inc/dec did not win last time goes now
          gnt = (last_grant == GNT_INC) ? GNT_DEC : GNT_INC;
        end else if (pend_inc) begin
          gnt = GNT_INC;
        end else if (pend_dec) begin
          gnt = GNT_DEC;
        end
        if (gnt != GNT_NONE) begin
          state_nxt    = HOLDOFF;
          hold_cnt_nxt = HOLD_W'(N_HOLDOFF);
        end
      end
      HOLDOFF: begin
        if (hold_cnt <= HOLD_W'(1)) begin
          state_nxt    = IDLE;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt - HOLD_W'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        hold_cnt_nxt = '0;
      end
    endcase

    case (gnt)
      GNT_CLR: count_nxt = '0;
      GNT_INC: begin
        if (count == CNT_MAX) begin
          ovf_nxt = 1'b1;
          if (WRAP != 0) count_nxt = '0;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end
      GNT_DEC: begin
        if (count == '0) begin
          unf_nxt = 1'b1;
          if (WRAP != 0) count_nxt = CNT_MAX;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // Counter, acknowledge/flag pulses, round-robin memory and sticky lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      ack_inc    <= 1'b0;
      ack_dec    <= 1'b0;
      ack_clr    <= 1'b0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      lost       <= 1'b0;
      last_grant <= GNT_DEC;
    end else begin
      count   <= count_nxt;
      ack_inc <= (gnt == GNT_INC);
      ack_dec <= (gnt == GNT_DEC);
      ack_clr <= gnt_clr;
      ovf     <= ovf_nxt;
      unf     <= unf_nxt;
      if (gnt == GNT_INC || gnt == GNT_DEC) last_grant <= gnt;
      if (gnt_clr) begin
        lost <= 1'b0;
      end else if (hit_inc || hit_dec || hit_clr) begin
        lost <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_inc_dec_arbiter.sv
// Directed bench for inc_dec_arbiter: instance A wraps (16 bit, holdoff 4),
// instance B saturates (4 bit, holdoff 2). Expected grants are queued when
// stimulus is driven and checked when an ack appears.
module tb_inc_dec_arbiter;
  import pb_ctrl_pkg::*;

  localparam int AH = 4;
  localparam int BH = 2;

  typedef struct {
    grant_e      kind;
    logic [15:0] cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_inc = 1'b0, a_dec = 1'b0, a_clr = 1'b0;
  logic [15:0] a_count;
  logic        a_ack_inc, a_ack_dec, a_ack_clr, a_busy, a_ovf, a_unf, a_lost;

  logic        b_inc = 1'b0, b_dec = 1'b0, b_clr = 1'b0;
  logic [3:0]  b_count;
  logic        b_ack_inc, b_ack_dec, b_ack_clr, b_busy, b_ovf, b_unf, b_lost;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  inc_dec_arbiter #(.WIDTH(16), .N_HOLDOFF(AH), .WRAP(1)) u_dut_a (
    .clk(clk), .rst(rst), .inc_req(a_inc), .dec_req(a_dec), .clr_req(a_clr),
    .count(a_count), .ack_inc(a_ack_inc), .ack_dec(a_ack_dec), .ack_clr(a_ack_clr),
    .busy(a_busy), .ovf(a_ovf), .unf(a_unf), .lost(a_lost)
  );

  inc_dec_arbiter #(.WIDTH(4), .N_HOLDOFF(BH), .WRAP(0)) u_dut_b (
    .clk(clk), .rst(rst), .inc_req(b_inc), .dec_req(b_dec), .clr_req(b_clr),
    .count(b_count), .ack_inc(b_ack_inc), .ack_dec(b_ack_dec), .ack_clr(b_ack_clr),
    .busy(b_busy), .ovf(b_ovf), .unf(b_unf), .lost(b_lost)
  );

  function automatic grant_e ack_kind(logic i, logic d, logic c);
    if (c) return GNT_CLR;
    if (d) return GNT_DEC;
    if (i) return GNT_INC;
    return GNT_NONE;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(grant_e k, logic [15:0] c, logic o, logic u);
    exp_t e;
    e.kind = k; e.cnt = c; e.ovf = o; e.unf = u;
    qa.push_back(e);
  endtask

  task automatic push_b(grant_e k, logic [15:0] c, logic o, logic u);
    exp_t e;
    e.kind = k; e.cnt = c; e.ovf = o; e.unf = u;
    qb.push_back(e);
  endtask

  task automatic pulse_a(logic i, logic d, logic c);
    a_inc = i; a_dec = d; a_clr = c;
    tick();
    a_inc = 1'b0; a_dec = 1'b0; a_clr = 1'b0;
  endtask

  task automatic pulse_b(logic i, logic d, logic c);
    b_inc = i; b_dec = d; b_clr = c;
    tick();
    b_inc = 1'b0; b_dec = 1'b0; b_clr = 1'b0;
  endtask

  // single isolated request on A: expect grant next edge, then sit out holdoff
  task automatic op_a(grant_e k, logic [15:0] c, logic o, logic u);
    push_a(k, c, o, u);
    pulse_a(k == GNT_INC, k == GNT_DEC, k == GNT_CLR);
    tick();
    chk("a_op_count", a_count, c);
    tick(AH);
  endtask

  task automatic op_b(grant_e k, logic [15:0] c, logic o, logic u);
    push_b(k, c, o, u);
    pulse_b(k == GNT_INC, k == GNT_DEC, k == GNT_CLR);
    tick();
    chk("b_op_count", b_count, c);
    tick(BH);
  endtask

  // scoreboard for A: every ack must match the oldest expected grant
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      n_vec++;
      assert ($onehot0({a_ack_inc, a_ack_dec, a_ack_clr})) else begin
        n_err++;
        $error("FAIL a_ack_onehot observed=%b expected=onehot0", {a_ack_inc, a_ack_dec, a_ack_clr});
      end
      if (a_ack_inc || a_ack_dec || a_ack_clr) begin
        n_vec++;
        assert (qa.size() > 0) else begin
          n_err++;
          $error("FAIL a_unexpected_ack observed=%b expected=none", {a_ack_inc, a_ack_dec, a_ack_clr});
        end
        if (qa.size() > 0) begin
          e = qa.pop_front();
          n_vec++;
          assert ({ack_kind(a_ack_inc, a_ack_dec, a_ack_clr), a_count, a_ovf, a_unf} ===
                  {e.kind, e.cnt, e.ovf, e.unf}) else begin
            n_err++;
            $error("FAIL a_grant observed=%0d/%0h/%b%b expected=%0d/%0h/%b%b",
                   ack_kind(a_ack_inc, a_ack_dec, a_ack_clr), a_count, a_ovf, a_unf,
                   e.kind, e.cnt, e.ovf, e.unf);
          end
        end
      end else begin
        n_vec++;
        assert ({a_ovf, a_unf} === 2'b00) else begin
          n_err++;
          $error("FAIL a_flag_no_ack observed=%b%b expected=00", a_ovf, a_unf);
        end
      end
    end
  end

  // scoreboard for B
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      n_vec++;
      assert ($onehot0({b_ack_inc, b_ack_dec, b_ack_clr})) else begin
        n_err++;
        $error("FAIL b_ack_onehot observed=%b expected=onehot0", {b_ack_inc, b_ack_dec, b_ack_clr});
      end
      if (b_ack_inc || b_ack_dec || b_ack_clr) begin
        n_vec++;
        assert (qb.size() > 0) else begin
          n_err++;
          $error("FAIL b_unexpected_ack observed=%b expected=none", {b_ack_inc, b_ack_dec, b_ack_clr});
        end
        if (qb.size() > 0) begin
          e = qb.pop_front();
          n_vec++;
          assert ({ack_kind(b_ack_inc, b_ack_dec, b_ack_clr), 12'd0, b_count, b_ovf, b_unf} ===
                  {e.kind, e.cnt, e.ovf, e.unf}) else begin
            n_err++;
            $error("FAIL b_grant observed=%0d/%0h/%b%b expected=%0d/%0h/%b%b",
                   ack_kind(b_ack_inc, b_ack_dec, b_ack_clr), b_count, b_ovf, b_unf,
                   e.kind, e.cnt, e.ovf, e.unf);
          end
        end
      end else begin
        n_vec++;
        assert ({b_ovf, b_unf} === 2'b00) else begin
          n_err++;
          $error("FAIL b_flag_no_ack observed=%b%b expected=00", b_ovf, b_unf);
        end
      end
    end
  end

  initial begin
    // reset values
    tick(3);
    chk("rst_a_count", a_count, 0);
    chk("rst_a_flags", {a_ack_inc, a_ack_dec, a_ack_clr, a_busy, a_ovf, a_unf, a_lost}, 0);
    chk("rst_b_count", b_count, 0);
    chk("rst_b_flags", {b_ack_inc, b_ack_dec, b_ack_clr, b_busy, b_ovf, b_unf, b_lost}, 0);
    rst = 1'b0;
    tick(2);

    // single inc: one-edge latency, busy for exactly AH cycles
    push_a(GNT_INC, 16'd1, 1'b0, 1'b0);
    pulse_a(1'b1, 1'b0, 1'b0);
    chk("lat_count_before", a_count, 0);
    chk("lat_busy_before", a_busy, 0);
    tick();
    chk("lat_count", a_count, 1);
    chk("lat_ack_inc", a_ack_inc, 1);
    chk("lat_busy_first", a_busy, 1);
    tick(AH - 1);
    chk("busy_last", a_busy, 1);
    tick();
    chk("busy_idle", a_busy, 0);

    // walk up to 6, then back to 5 so the last inc/dec grant was dec
    for (int v = 2; v <= 6; v++) op_a(GNT_INC, 16'(v), 1'b0, 1'b0);
    op_a(GNT_DEC, 16'd5, 1'b0, 1'b0);

    // simultaneous inc+dec: inc first, dec after holdoff, nothing lost
    push_a(GNT_INC, 16'd6, 1'b0, 1'b0);
    push_a(GNT_DEC, 16'd5, 1'b0, 1'b0);
    pulse_a(1'b1, 1'b1, 1'b0);
    tick();
    chk("rr_first_inc", {a_ack_inc, a_count}, {1'b1, 16'd6});
    tick(AH + 1);
    chk("rr_then_dec", {a_ack_dec, a_count}, {1'b1, 16'd5});
    chk("rr_no_lost", a_lost, 0);
    tick(AH);

    // clear, then wrap in both directions
    op_a(GNT_CLR, 16'd0, 1'b0, 1'b0);
    op_a(GNT_DEC, 16'hFFFF, 1'b0, 1'b1);
    op_a(GNT_INC, 16'h0000, 1'b1, 1'b0);
    op_a(GNT_DEC, 16'hFFFF, 1'b0, 1'b1);

    // request on its own grant edge re-arms without lost
    push_a(GNT_INC, 16'h0000, 1'b1, 1'b0);
    push_a(GNT_INC, 16'h0001, 1'b0, 1'b0);
    pulse_a(1'b1, 1'b0, 1'b0);
    pulse_a(1'b1, 1'b0, 1'b0);
    chk("rearm_count", a_count, 0);
    chk("rearm_no_lost", a_lost, 0);
    tick(AH + 1);
    chk("rearm_second", a_count, 1);
    tick(AH);

    // three incs during holdoff merge into one further grant and set lost
    push_a(GNT_INC, 16'd2, 1'b0, 1'b0);
    push_a(GNT_INC, 16'd3, 1'b0, 1'b0);
    pulse_a(1'b1, 1'b0, 1'b0);
    tick();
    repeat (3) pulse_a(1'b1, 1'b0, 1'b0);
    chk("merge_lost", a_lost, 1);
    tick();
    chk("merge_held", a_count, 2);
    tick();
    chk("merge_one_grant", a_count, 3);
    tick(AH + 4);
    push_a(GNT_CLR, 16'd0, 1'b0, 1'b0);
    pulse_a(1'b0, 1'b0, 1'b1);
    tick();
    chk("clr_count", a_count, 0);
    chk("clr_lost", a_lost, 0);
    tick(AH);

    // clr beats inc/dec on the same edge and flushes them
    op_a(GNT_INC, 16'd1, 1'b0, 1'b0);
    push_a(GNT_CLR, 16'd0, 1'b0, 1'b0);
    pulse_a(1'b1, 1'b1, 1'b1);
    tick();
    chk("flush_ack_clr", {a_ack_clr, a_count}, {1'b1, 16'd0});
    tick(AH + 6);
    chk("flush_stays_zero", a_count, 0);

    // async reset mid-holdoff with dec pending and lost set
    push_a(GNT_INC, 16'd1, 1'b0, 1'b0);
    pulse_a(1'b1, 1'b0, 1'b0);
    tick();
    pulse_a(1'b0, 1'b1, 1'b0);
    pulse_a(1'b0, 1'b1, 1'b0);
    chk("pre_rst_state", {a_busy, a_lost, a_count}, {1'b1, 1'b1, 16'd1});
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", a_count, 0);
    chk("async_rst_flags", {a_ack_inc, a_ack_dec, a_ack_clr, a_busy, a_ovf, a_unf, a_lost}, 0);
    tick();
    rst = 1'b0;
    tick(12);
    chk("post_rst_count", a_count, 0);
    chk("post_rst_busy", a_busy, 0);
    chk("a_queue_drained", qa.size(), 0);

    // saturating instance: dec at 0 holds, busy for BH cycles
    push_b(GNT_DEC, 16'd0, 1'b0, 1'b1);
    pulse_b(1'b0, 1'b1, 1'b0);
    tick();
    chk("sat_dec_zero", {b_count, b_ack_dec, b_unf, b_busy}, {4'd0, 1'b1, 1'b1, 1'b1});
    tick(BH - 1);
    chk("b_busy_last", b_busy, 1);
    tick();
    chk("b_busy_idle", b_busy, 0);
    for (int v = 1; v <= 15; v++) op_b(GNT_INC, 16'(v), 1'b0, 1'b0);
    op_b(GNT_INC, 16'd15, 1'b1, 1'b0);
    op_b(GNT_DEC, 16'd14, 1'b0, 1'b0);
    tick(4);
    chk("b_queue_drained", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
